// File: rtl/id_ex_if.sv
// ----------------------------------------------------------------------------
// id_ex_if: bundle for the ID/EX pipeline register boundary.
//
// Groups the hazard-control inputs (Stall, Flush), the decode-stage fields
// going into the register (*_IN) and the registered fields going to the
// execute stage (*_OUT). Clock and reset are not part of the bundle.
//
// Modports:
//   master - decode stage / hazard unit side: drives Stall, Flush and *_IN,
//            observes *_OUT.
//   slave  - the id_ex register itself: receives Stall, Flush and *_IN,
//            drives *_OUT.
// ----------------------------------------------------------------------------
interface id_ex_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned WB_W   = 2,
    parameter int unsigned MEM_W  = 3,
    parameter int unsigned EX_W   = 4
) ();

    // Hazard-unit control
    logic              Stall;
    logic              Flush;

    // Decode-stage fields
    logic [DATA_W-1:0] PC_IN;
    logic [DATA_W-1:0] RD1_IN;
    logic [DATA_W-1:0] RD2_IN;
    logic [DATA_W-1:0] IR_LO_EX_IN;
    logic [REG_W-1:0]  WR1_IN;
    logic [REG_W-1:0]  WR2_IN;
    logic [WB_W-1:0]   WB_IN;
    logic [MEM_W-1:0]  MEM_IN;
    logic [EX_W-1:0]   EX_IN;

    // Registered fields presented to the execute stage
    logic [DATA_W-1:0] PC_OUT;
    logic [DATA_W-1:0] RD1_OUT;
    logic [DATA_W-1:0] RD2_OUT;
    logic [DATA_W-1:0] IR_LO_EX_OUT;
    logic [REG_W-1:0]  WR1_OUT;
    logic [REG_W-1:0]  WR2_OUT;
    logic [WB_W-1:0]   WB_OUT;
    logic [MEM_W-1:0]  MEM_OUT;
    logic [EX_W-1:0]   EX_OUT;

    modport master (
        output Stall, Flush,
        output PC_IN, RD1_IN, RD2_IN, IR_LO_EX_IN,
        output WR1_IN, WR2_IN, WB_IN, MEM_IN, EX_IN,
        input  PC_OUT, RD1_OUT, RD2_OUT, IR_LO_EX_OUT,
        input  WR1_OUT, WR2_OUT, WB_OUT, MEM_OUT, EX_OUT
    );

    modport slave (
        input  Stall, Flush,
        input  PC_IN, RD1_IN, RD2_IN, IR_LO_EX_IN,
        input  WR1_IN, WR2_IN, WB_IN, MEM_IN, EX_IN,
        output PC_OUT, RD1_OUT, RD2_OUT, IR_LO_EX_OUT,
        output WR1_OUT, WR2_OUT, WB_OUT, MEM_OUT, EX_OUT
    );

endinterface

// File: rtl/id_ex.sv
// ----------------------------------------------------------------------------
// id_ex: ID/EX pipeline register of the 5-stage MIPS pipeline.
//
// Captures the decode-stage values on the rising edge of Clk and presents
// them to the execute stage: PC+4, both register-file read values, the
// sign-extended immediate, the rt/rd destination candidates and the
// WB/MEM/EX control groups. All fields are opaque; nothing is decoded here.
//
// Ports:
//   Clk  - clock, all state changes on the rising edge
//   Rst  - synchronous active-high reset, clears every field
//   bus  - id_ex_if.slave: Stall/Flush hazard controls, *_IN fields in,
//          *_OUT fields out (driven straight from flops)
//
// Per-edge priority: Rst > Flush > Stall > load. Flush writes an all-zero
// bubble, which the later stages treat as a NOP because no control bit is
// set. Stall simply holds the current contents.
// ----------------------------------------------------------------------------
module id_ex #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned WB_W   = 2,
    parameter int unsigned MEM_W  = 3,
    parameter int unsigned EX_W   = 4
) (
    input  logic    Clk,
    input  logic    Rst,
    id_ex_if.slave  bus
);

    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] rd1_q;
    logic [DATA_W-1:0] rd2_q;
    logic [DATA_W-1:0] ir_lo_ex_q;
    logic [REG_W-1:0]  wr1_q;
    logic [REG_W-1:0]  wr2_q;
    logic [WB_W-1:0]   wb_q;
    logic [MEM_W-1:0]  mem_q;
    logic [EX_W-1:0]   ex_q;

    // Reset and flush share the clear path; reset still wins because it is
    // tested first, and both dominate stall so a bubble lands even while the
    // hazard unit is holding the front of the pipe.
    always_ff @(posedge Clk) begin
        if (Rst || bus.Flush) begin
            pc_q       <= '0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            ir_lo_ex_q <= '0;
            wr1_q      <= '0;
            wr2_q      <= '0;
            wb_q       <= '0;
            mem_q      <= '0;
            ex_q       <= '0;
        end else if (!bus.Stall) begin
            pc_q       <= bus.PC_IN;
            rd1_q      <= bus.RD1_IN;
            rd2_q      <= bus.RD2_IN;
            ir_lo_ex_q <= bus.IR_LO_EX_IN;
            wr1_q      <= bus.WR1_IN;
            wr2_q      <= bus.WR2_IN;
            wb_q       <= bus.WB_IN;
            mem_q      <= bus.MEM_IN;
            ex_q       <= bus.EX_IN;
        end
    end

    // Outputs come straight off the flops: no input reaches an output
    // within the same cycle.
    assign bus.PC_OUT       = pc_q;
    assign bus.RD1_OUT      = rd1_q;
    assign bus.RD2_OUT      = rd2_q;
    assign bus.IR_LO_EX_OUT = ir_lo_ex_q;
    assign bus.WR1_OUT      = wr1_q;
    assign bus.WR2_OUT      = wr2_q;
    assign bus.WB_OUT       = wb_q;
    assign bus.MEM_OUT      = mem_q;
    assign bus.EX_OUT       = ex_q;

endmodule

// File: tb/tb_id_ex.sv
// ----------------------------------------------------------------------------
// tb_id_ex: self-checking bench for id_ex.
//
// A driver applies one directed vector per cycle just after the falling edge
// and queues the hand-computed value the outputs must hold after the next
// rising edge. A monitor samples the outputs 1 time unit after each rising
// edge and checks them against the queue. A second queue holds checks taken
// shortly after new inputs are applied, before the rising edge, to confirm
// the outputs have not moved yet.
// ----------------------------------------------------------------------------
module tb_id_ex;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned WB_W   = 2;
    localparam int unsigned MEM_W  = 3;
    localparam int unsigned EX_W   = 4;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] ir;
        logic [REG_W-1:0]  wr1;
        logic [REG_W-1:0]  wr2;
        logic [WB_W-1:0]   wb;
        logic [MEM_W-1:0]  mem;
        logic [EX_W-1:0]   ex;
    } vec_t;

    typedef struct {
        string name;
        vec_t  v;
    } exp_t;

    logic clk;
    logic rst;

    id_ex_if #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W),
        .WB_W   (WB_W),
        .MEM_W  (MEM_W),
        .EX_W   (EX_W)
    ) bus_if ();

    id_ex #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W),
        .WB_W   (WB_W),
        .MEM_W  (MEM_W),
        .EX_W   (EX_W)
    ) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t post_q[$];
    exp_t pre_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    // Directed vectors (field order: pc, rd1, rd2, ir, wr1, wr2, wb, mem, ex)
    localparam vec_t VZ   = '0;
    localparam vec_t V1   = '{32'd5, 32'd2, 32'd31, 32'd5, 5'd2, 5'd3, 2'd3, 3'd4, 4'd5};
    localparam vec_t V2   = '{32'd50, 32'd1, 32'd1, 32'd1, 5'd1, 5'd0, 2'd1, 3'd2, 4'd9};
    localparam vec_t VMAX = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              5'd31, 5'd31, 2'd3, 3'd7, 4'd15};
    localparam vec_t VA   = '{32'h1234_5678, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'hFFFF_FFF0,
                              5'd7, 5'd12, 2'd2, 3'd5, 4'hA};
    localparam vec_t VB   = '{32'h0000_0040, 32'h11, 32'h22, 32'h33,
                              5'd1, 5'd2, 2'd1, 3'd1, 4'd1};

    function automatic vec_t sample_out();
        vec_t s;
        s.pc  = bus_if.PC_OUT;
        s.rd1 = bus_if.RD1_OUT;
        s.rd2 = bus_if.RD2_OUT;
        s.ir  = bus_if.IR_LO_EX_OUT;
        s.wr1 = bus_if.WR1_OUT;
        s.wr2 = bus_if.WR2_OUT;
        s.wb  = bus_if.WB_OUT;
        s.mem = bus_if.MEM_OUT;
        s.ex  = bus_if.EX_OUT;
        return s;
    endfunction

    task automatic apply_in(input vec_t v);
        bus_if.PC_IN       = v.pc;
        bus_if.RD1_IN      = v.rd1;
        bus_if.RD2_IN      = v.rd2;
        bus_if.IR_LO_EX_IN = v.ir;
        bus_if.WR1_IN      = v.wr1;
        bus_if.WR2_IN      = v.wr2;
        bus_if.WB_IN       = v.wb;
        bus_if.MEM_IN      = v.mem;
        bus_if.EX_IN       = v.ex;
    endtask

    task automatic compare(input string name, input vec_t got, input vec_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got pc=%h rd1=%h rd2=%h ir=%h wr1=%h wr2=%h wb=%h mem=%h ex=%h ; want pc=%h rd1=%h rd2=%h ir=%h wr1=%h wr2=%h wb=%h mem=%h ex=%h",
                     name, got.pc, got.rd1, got.rd2, got.ir, got.wr1, got.wr2, got.wb,
                     got.mem, got.ex, exp.pc, exp.rd1, exp.rd2, exp.ir, exp.wr1, exp.wr2,
                     exp.wb, exp.mem, exp.ex);
        end
    endtask

    // One stimulus cycle: controls + inputs, the outputs expected after the
    // coming rising edge and, optionally, the outputs expected before it.
    task automatic step(input string name, input logic r, input logic f, input logic s,
                        input vec_t in_v, input vec_t exp_v,
                        input bit chk_pre, input vec_t pre_v);
        exp_t e;
        @(negedge clk);
        #1;
        rst          = r;
        bus_if.Flush = f;
        bus_if.Stall = s;
        apply_in(in_v);
        if (chk_pre) begin
            e.name = {name, "_pre_edge"};
            e.v    = pre_v;
            pre_q.push_back(e);
        end
        e.name = name;
        e.v    = exp_v;
        post_q.push_back(e);
    endtask

    // Post-edge monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (post_q.size() != 0) begin
                e = post_q.pop_front();
                compare(e.name, sample_out(), e.v);
            end
        end
    end

    // Pre-edge monitor: runs after the driver has changed inputs mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (pre_q.size() != 0) begin
                e = pre_q.pop_front();
                compare(e.name, sample_out(), e.v);
            end
        end
    end

    initial begin
        rst          = 1'b1;
        bus_if.Flush = 1'b0;
        bus_if.Stall = 1'b0;
        apply_in(VMAX);

        // Reset with arbitrary inputs, then release with inputs held
        step("reset_1",      1'b1, 1'b0, 1'b0, VMAX, VZ,   1'b0, VZ);
        step("reset_2",      1'b1, 1'b0, 1'b0, VMAX, VZ,   1'b0, VZ);
        step("reset_release",1'b0, 1'b0, 1'b0, VMAX, VMAX, 1'b0, VZ);

        // Load and reload, each checked before and after the edge
        step("load",         1'b0, 1'b0, 1'b0, V1,   V1,   1'b1, VMAX);
        step("reload",       1'b0, 1'b0, 1'b0, V2,   V2,   1'b1, V1);

        // Stall for three edges with maximum inputs, then release
        step("stall_1",      1'b0, 1'b0, 1'b1, VMAX, V2,   1'b1, V2);
        step("stall_2",      1'b0, 1'b0, 1'b1, VMAX, V2,   1'b0, VZ);
        step("stall_3",      1'b0, 1'b0, 1'b1, VMAX, V2,   1'b0, VZ);
        step("unstall",      1'b0, 1'b0, 1'b0, VMAX, VMAX, 1'b0, VZ);

        // Flush beats stall; next clean edge loads
        step("flush_stall",  1'b0, 1'b1, 1'b1, VA,   VZ,   1'b0, VZ);
        step("post_flush",   1'b0, 1'b0, 1'b0, VA,   VA,   1'b0, VZ);

        // Reset beats stall
        step("rst_over_stall",1'b1, 1'b0, 1'b1, VB,  VZ,   1'b0, VZ);

        // Back-to-back alternating vectors, one-cycle latency
        step("alt_1",        1'b0, 1'b0, 1'b0, VA,   VA,   1'b0, VZ);
        step("alt_2",        1'b0, 1'b0, 1'b0, VB,   VB,   1'b0, VZ);
        step("alt_3",        1'b0, 1'b0, 1'b0, VA,   VA,   1'b0, VZ);
        step("alt_4",        1'b0, 1'b0, 1'b0, VB,   VB,   1'b0, VZ);

        // Flush alone, a stall holding the bubble, then reload
        step("flush_only",   1'b0, 1'b1, 1'b0, VA,   VZ,   1'b0, VZ);
        step("stall_bubble", 1'b0, 1'b0, 1'b1, VA,   VZ,   1'b0, VZ);
        step("after_bubble", 1'b0, 1'b0, 1'b0, VB,   VB,   1'b0, VZ);

        // Rst wins even with Flush and Stall also high
        step("rst_all_high", 1'b1, 1'b1, 1'b1, VA,   VZ,   1'b0, VZ);

        // Let the monitors drain
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);

        n_checks++;
        if (post_q.size() != 0 || pre_q.size() != 0) begin
            n_fails++;
            $display("FAIL drain: got %0d/%0d pending checks, want 0/0",
                     post_q.size(), pre_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
